// File: rtl/accumulating_adder_ctrl.sv
// Burst accumulator front-end for the 16-bit ripple-carry adder.
// Sums a valid/ready operand stream into a 16-bit accumulator, counts
// carry-outs and operands (saturating), tracks sticky signed overflow and
// holds the burst result on a valid/ready output port until consumed.

// One bit slice of the ripple-carry adder.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// 16-bit ripple-carry adder built from an array of bit slices.
module rca16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  logic [W:0] c;

  assign c[0]  = c_in;
  assign c_out = c[W];

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    rca_full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (c[gi]),
      .s  (sum[gi]),
      .co (c[gi+1])
    );
  end
endmodule

module accumulating_adder_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic [15:0]      add_sum;
  logic             add_co;
  logic             xfer;

  rca16 #(.W(16)) u_add (
    .a     (acc_q),
    .b     (in_data),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // Ready is a pure decode of registered state, never of in_valid.
  assign in_ready = (state_q != DONE);
  assign xfer     = in_valid & in_ready;

  assign out_valid   = out_valid_q;
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_ovf     = ovf_q;
  assign out_count   = count_q;
  assign out_sat     = sat_q;

  // Next-state: accumulate on transfer, hold result in DONE, clear on consume.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          acc_d = add_sum;
          if (add_co) begin
            if (carries_q == CNT_MAX) sat_d = 1'b1;
            else                      carries_d = carries_q + CNT_ONE;
          end
          if (count_q == CNT_MAX) sat_d = 1'b1;
          else                    count_d = count_q + CNT_ONE;
          // Same-sign operands producing an opposite-sign result.
          if ((acc_q[15] == in_data[15]) && (add_sum[15] != acc_q[15]))
            ovf_d = 1'b1;
          if (in_last) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          carries_d   = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          sat_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_accumulating_adder_ctrl.sv
// Self-checking bench: directed bursts plus random traffic, checked every
// cycle against an arithmetic model of the burst accumulator.
module tb_accumulating_adder_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_carries;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: unbounded integer accumulation, clamped only when compared.
  int m_acc, m_carr, m_cnt;
  bit m_ovf, m_done;

  accumulating_adder_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_ovf     (out_ovf),
    .out_count   (out_count),
    .out_sat     (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampc(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic m_clear();
    m_acc = 0; m_carr = 0; m_cnt = 0; m_ovf = 0;
  endtask

  // One clock: update model from the driven inputs, then compare outputs.
  task automatic step();
    int full, sa, sd, ss;
    @(posedge clk);
    if (rst) begin
      m_clear(); m_done = 0;
    end else if (m_done) begin
      if (out_ready) begin m_clear(); m_done = 0; end
    end else if (in_valid) begin
      full = m_acc + int'(in_data);
      sa = int'($signed(m_acc[15:0]));
      sd = int'($signed(in_data));
      ss = sa + sd;
      if (ss > 32767 || ss < -32768) m_ovf = 1;
      if (full > 16'hFFFF) m_carr++;
      m_cnt++;
      m_acc = full & 16'hFFFF;
      if (in_last) m_done = 1;
    end
    #1;
    chk("in_ready",    32'(in_ready),    32'(!m_done));
    chk("out_valid",   32'(out_valid),   32'(m_done));
    chk("out_sum",     32'(out_sum),     32'(m_acc));
    chk("out_carries", 32'(out_carries), 32'(clampc(m_carr)));
    chk("out_count",   32'(out_count),   32'(clampc(m_cnt)));
    chk("out_ovf",     32'(out_ovf),     32'(m_ovf));
    chk("out_sat",     32'(out_sat),     32'((m_carr > CMAX) || (m_cnt > CMAX)));
  endtask

  task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                     input logic l, input logic ordy);
    rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    step();
  endtask

  initial begin
    m_clear(); m_done = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 16'hABCD, 1, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum",   32'(out_sum),   0);
    chk("rst_ready", 32'(in_ready),  1);

    // Single operand burst
    cyc(0, 1, 16'h1234, 1, 0);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_sum",   32'(out_sum), 32'h1234);
    chk("single_count", 32'(out_count), 1);
    chk("single_carr",  32'(out_carries), 0);
    chk("single_ovf",   32'(out_ovf), 0);
    cyc(0, 0, 0, 0, 1);
    chk("single_idle", 32'(out_valid), 0);

    // Carry / overflow burst
    cyc(0, 1, 16'hFFFF, 0, 0);
    cyc(0, 1, 16'h0001, 0, 0);
    cyc(0, 1, 16'h8000, 0, 0);
    cyc(0, 1, 16'h8000, 1, 0);
    chk("co_sum",   32'(out_sum), 0);
    chk("co_carr",  32'(out_carries), 2);
    chk("co_ovf",   32'(out_ovf), 1);
    chk("co_count", 32'(out_count), 4);
    chk("co_sat",   32'(out_sat), 0);
    cyc(0, 0, 0, 0, 1);

    // Saturation: 18 x 0xFFFF
    for (int i = 0; i < 18; i++) cyc(0, 1, 16'hFFFF, (i == 17), 0);
    chk("sat_carr",  32'(out_carries), 15);
    chk("sat_count", 32'(out_count), 15);
    chk("sat_flag",  32'(out_sat), 1);
    chk("sat_sum",   32'(out_sum), 32'hFFEE);
    cyc(0, 0, 0, 0, 1);

    // Backpressure with pending input in DONE
    cyc(0, 1, 16'h0001, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 16'h0005, 0, 0);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_sum",   32'(out_sum), 1);
      chk("bp_count", 32'(out_count), 1);
    end
    cyc(0, 1, 16'h0005, 0, 1);
    chk("bp_release", 32'(out_valid), 0);
    chk("bp_cleared", 32'(out_sum), 0);
    cyc(0, 1, 16'h0005, 0, 0);
    chk("bp_accept", 32'(out_sum), 5);
    cyc(0, 1, 16'h0000, 1, 0);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-burst
    cyc(0, 1, 16'h0100, 0, 0);
    cyc(0, 1, 16'h0200, 0, 0);
    cyc(1, 1, 16'h0400, 1, 0);
    chk("mrst_sum",   32'(out_sum), 0);
    chk("mrst_count", 32'(out_count), 0);
    cyc(0, 1, 16'h0003, 1, 0);
    chk("mrst_sum2",  32'(out_sum), 3);
    chk("mrst_cnt2",  32'(out_count), 1);
    cyc(0, 0, 0, 0, 1);

    // Gapped input
    cyc(0, 1, 16'h7FFF, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'hDEAD, 1, 0);
    cyc(0, 1, 16'h0001, 1, 0);
    chk("gap_sum",   32'(out_sum), 32'h8000);
    chk("gap_ovf",   32'(out_ovf), 1);
    chk("gap_carr",  32'(out_carries), 0);
    chk("gap_count", 32'(out_count), 2);
    cyc(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF;
        1:       d = 16'h8000 | 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 7), d,
          ($urandom_range(0, 9) < 1),
          ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
